// File: rtl/seq_match_pkg.sv
// State encodings and index sizing shared by the pattern-matching FSM and its pattern store.
package seq_match_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ST_SEEK  = 2'd1;
  localparam logic [STATE_W-1:0] ST_TRACK = 2'd2;

  // Wide enough to hold every length 0..depth and every index 0..depth-1.
  function automatic int idx_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/seq_pat_store.sv
// Pattern, length and overlap registers with their load path.
// Loads take effect the cycle after i_ld; symbol lookups are combinational.
module seq_pat_store
  import seq_match_pkg::*;
#(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 4,
  localparam int LW    = idx_width(DEPTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_ld,
  input  logic [LW-1:0]          i_len,
  input  logic [DEPTH*WIDTH-1:0] i_pat,
  input  logic                   i_ovl,
  input  logic [LW-1:0]          i_idx,
  output logic [WIDTH-1:0]       o_pat_idx,
  output logic [WIDTH-1:0]       o_pat0,
  output logic [LW-1:0]          o_len,
  output logic                   o_ovl,
  output logic                   o_len_ok,
  output logic                   o_cfg_len_bad
);

  logic [WIDTH-1:0] r_pat [DEPTH];
  logic [LW-1:0]    r_len;
  logic             r_ovl;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_pat[k] <= '0;
      r_len <= '0;
      r_ovl <= 1'b0;
    end else if (i_ld) begin
      for (int k = 0; k < DEPTH; k++) r_pat[k] <= i_pat[k*WIDTH +: WIDTH];
      r_len <= i_len;
      r_ovl <= i_ovl;
    end
  end

  always_comb begin
    o_pat_idx = r_pat[0];
    for (int k = 1; k < DEPTH; k++) begin
      if (i_idx == LW'(k)) o_pat_idx = r_pat[k];
    end
  end

  assign o_pat0        = r_pat[0];
  assign o_len         = r_len;
  assign o_ovl         = r_ovl;
  assign o_len_ok      = (r_len != '0) && (r_len <= LW'(DEPTH));
  // An out-of-range length still loads; the caller flags it as a config error.
  assign o_cfg_len_bad = (i_len == '0) || (i_len > LW'(DEPTH));

endmodule

// File: rtl/seq_match_fsm.sv
// Run-time programmable symbol-pattern detector with hit pulse, sticky flag and saturating count.
// Hit is registered 1 clk after the final matching symbol; in_vld qualifies input, no backpressure.
module seq_match_fsm
  import seq_match_pkg::*;
#(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 8,
  localparam int LW    = idx_width(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   cfg_wr,
  input  logic [LW-1:0]          cfg_len,
  input  logic [DEPTH*WIDTH-1:0] cfg_pat,
  input  logic                   cfg_overlap,
  input  logic                   in_vld,
  input  logic [WIDTH-1:0]       in_dat,
  input  logic                   clr,
  output logic                   hit,
  output logic                   flag,
  output logic [CNT_W-1:0]       hit_cnt,
  output logic                   busy,
  output logic                   cfg_err
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_nstate;
  logic [LW-1:0]      r_idx;
  logic [LW-1:0]      w_nidx;
  logic [LW-1:0]      w_idx_inc;
  logic [LW-1:0]      w_restart;
  logic [LW-1:0]      w_len;
  logic [WIDTH-1:0]   w_pat_idx;
  logic [WIDTH-1:0]   w_pat0;
  logic               w_ovl;
  logic               w_len_ok;
  logic               w_cfg_len_bad;
  logic               w_cfg_ld;
  logic               w_active;
  logic               w_eq;
  logic               w_eq0;
  logic               w_last;
  logic               w_match;
  logic               r_hit;
  logic               r_flag;
  logic               r_cfg_err;
  logic [CNT_W-1:0]   r_cnt;

  assign w_cfg_ld = cfg_wr && (r_state == ST_IDLE) && !en;

  seq_pat_store #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_store (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_ld          (w_cfg_ld),
    .i_len         (cfg_len),
    .i_pat         (cfg_pat),
    .i_ovl         (cfg_overlap),
    .i_idx         (r_idx),
    .o_pat_idx     (w_pat_idx),
    .o_pat0        (w_pat0),
    .o_len         (w_len),
    .o_ovl         (w_ovl),
    .o_len_ok      (w_len_ok),
    .o_cfg_len_bad (w_cfg_len_bad)
  );

  assign w_active  = (r_state == ST_SEEK) || (r_state == ST_TRACK);
  assign w_idx_inc = r_idx + 1'b1;
  assign w_eq      = (in_dat == w_pat_idx);
  assign w_eq0     = (in_dat == w_pat0);
  assign w_last    = (w_idx_inc == w_len);
  // Naive restart: only pat[0] is re-tested; a length-1 pattern never leaves index 0.
  assign w_restart = (w_eq0 && (w_len != LW'(1))) ? LW'(1) : '0;
  assign w_match   = w_active && en && in_vld && w_eq && w_last;

  always_comb begin
    w_nstate = r_state;
    w_nidx   = r_idx;
    case (r_state)
      ST_IDLE: begin
        w_nidx = '0;
        if (en && w_len_ok) w_nstate = ST_SEEK;
      end
      ST_SEEK, ST_TRACK: begin
        if (!en) begin
          w_nstate = ST_IDLE;
          w_nidx   = '0;
        end else if (in_vld) begin
          if (w_eq && !w_last)     w_nidx = w_idx_inc;
          else if (w_eq && !w_ovl) w_nidx = '0;
          else                     w_nidx = w_restart;
          w_nstate = (w_nidx == '0) ? ST_SEEK : ST_TRACK;
        end
      end
      default: begin
        w_nstate = ST_IDLE;
        w_nidx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_hit     <= 1'b0;
      r_flag    <= 1'b0;
      r_cnt     <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_idx     <= w_nidx;
      r_hit     <= w_match;
      r_flag    <= w_match || (r_flag && !clr);
      r_cfg_err <= cfg_wr && (!w_cfg_ld || w_cfg_len_bad);
      if (clr)                           r_cnt <= CNT_W'(w_match);
      else if (w_match && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign hit     = r_hit;
  assign flag    = r_flag;
  assign hit_cnt = r_cnt;
  assign busy    = (r_state != ST_IDLE);
  assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_seq_match_fsm.sv
// Bench: two detectors (1-bit/8-bit count and 4-bit/2-bit count) share one stimulus stream and are
// compared every cycle against a behavioural model, plus directed literal expectations.
module tb_seq_match_fsm;

  logic        clk = 1'b0;
  logic        rst_n, en, cfg_wr, cfg_overlap, in_vld, clr;
  logic [2:0]  cfg_len;
  logic [15:0] cfg_pat;
  logic [3:0]  in_dat;

  logic       a_hit, a_flag, a_busy, a_err;
  logic [7:0] a_cnt;
  logic       b_hit, b_flag, b_busy, b_err;
  logic [1:0] b_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_match_fsm #(.WIDTH(1), .DEPTH(4), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_wr(cfg_wr), .cfg_len(cfg_len),
    .cfg_pat(cfg_pat[3:0]), .cfg_overlap(cfg_overlap), .in_vld(in_vld), .in_dat(in_dat[0]),
    .clr(clr), .hit(a_hit), .flag(a_flag), .hit_cnt(a_cnt), .busy(a_busy), .cfg_err(a_err)
  );

  seq_match_fsm #(.WIDTH(4), .DEPTH(4), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_wr(cfg_wr), .cfg_len(cfg_len),
    .cfg_pat(cfg_pat), .cfg_overlap(cfg_overlap), .in_vld(in_vld), .in_dat(in_dat),
    .clr(clr), .hit(b_hit), .flag(b_flag), .hit_cnt(b_cnt), .busy(b_busy), .cfg_err(b_err)
  );

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Model: "running" flag plus length of the currently matched pattern prefix.
  int m_busy[2], m_idx[2], m_len[2], m_ovl[2], m_hit[2], m_flag[2], m_cnt[2], m_err[2];
  int m_pat[2][4];
  bit m_started = 1'b0;

  always @(posedge clk) begin : mdl
    int sym, cmax;
    bit match;
    m_started = 1'b1;
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        m_busy[u] = 0; m_idx[u] = 0; m_len[u] = 0; m_ovl[u] = 0;
        m_hit[u] = 0; m_flag[u] = 0; m_cnt[u] = 0; m_err[u] = 0;
        for (int k = 0; k < 4; k++) m_pat[u][k] = 0;
      end else begin
        sym   = (u == 0) ? int'(in_dat[0]) : int'(in_dat);
        cmax  = (u == 0) ? 255 : 3;
        match = 1'b0;
        m_err[u] = 0;
        if (cfg_wr) begin
          if (m_busy[u] == 0 && !en) begin
            m_len[u] = int'(cfg_len);
            m_ovl[u] = int'(cfg_overlap);
            for (int k = 0; k < 4; k++)
              m_pat[u][k] = (u == 0) ? int'(cfg_pat[k]) : int'(cfg_pat[4*k +: 4]);
            m_err[u] = (cfg_len == 0 || cfg_len > 4) ? 1 : 0;
          end else begin
            m_err[u] = 1;
          end
        end
        if (!en) begin
          m_busy[u] = 0;
          m_idx[u]  = 0;
        end else if (m_busy[u] == 0) begin
          if (m_len[u] >= 1 && m_len[u] <= 4) m_busy[u] = 1;
        end else if (in_vld) begin
          if (sym == m_pat[u][m_idx[u]]) begin
            if (m_idx[u] + 1 < m_len[u]) m_idx[u] = m_idx[u] + 1;
            else begin
              match    = 1'b1;
              m_idx[u] = (m_ovl[u] != 0 && m_len[u] > 1 && sym == m_pat[u][0]) ? 1 : 0;
            end
          end else begin
            m_idx[u] = (m_len[u] > 1 && sym == m_pat[u][0]) ? 1 : 0;
          end
        end
        m_hit[u]  = int'(match);
        m_flag[u] = (match || (m_flag[u] != 0 && !clr)) ? 1 : 0;
        if (clr) m_cnt[u] = int'(match);
        else if (match && m_cnt[u] < cmax) m_cnt[u] = m_cnt[u] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("cyc_a_hit",  a_hit,  m_hit[0]);
      chk("cyc_a_flag", a_flag, m_flag[0]);
      chk("cyc_a_cnt",  a_cnt,  m_cnt[0]);
      chk("cyc_a_busy", a_busy, m_busy[0]);
      chk("cyc_a_err",  a_err,  m_err[0]);
      chk("cyc_b_hit",  b_hit,  m_hit[1]);
      chk("cyc_b_flag", b_flag, m_flag[1]);
      chk("cyc_b_cnt",  b_cnt,  m_cnt[1]);
      chk("cyc_b_busy", b_busy, m_busy[1]);
      chk("cyc_b_err",  b_err,  m_err[1]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [2:0] len, input logic [15:0] pat, input logic ovl);
    en = 1'b0; in_vld = 1'b0;
    step();
    cfg_wr = 1'b1; cfg_len = len; cfg_pat = pat; cfg_overlap = ovl;
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic start();
    en = 1'b1;
    step();
  endtask

  task automatic sym(input logic [3:0] d);
    in_vld = 1'b1; in_dat = d;
    step();
    in_vld = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  int exp_ov1[4] = '{0, 1, 1, 1};
  int exp_ov0[4] = '{0, 1, 0, 1};
  int exp_sat[5] = '{1, 2, 3, 3, 3};

  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_wr = 1'b0; cfg_len = '0; cfg_pat = '0;
    cfg_overlap = 1'b0; in_vld = 1'b0; in_dat = '0; clr = 1'b0;
    step(); step();
    chk("rst_hit", a_hit, 0); chk("rst_flag", a_flag, 0); chk("rst_cnt", a_cnt, 0);
    chk("rst_busy", a_busy, 0); chk("rst_err", a_err, 0);
    rst_n = 1'b1;

    // Pattern 1,1,0 non-overlapping on the 1-bit detector.
    cfg(3'd3, 16'h0003, 1'b0);
    chk("t1_cfg_err", a_err, 0);
    start();
    chk("t1_busy", a_busy, 1);
    sym(4'd1); sym(4'd1); sym(4'd0);
    chk("t1_hit_a", a_hit, 1);
    sym(4'd1);
    chk("t1_pulse", a_hit, 0);
    sym(4'd1); sym(4'd0);
    chk("t1_hit_b", a_hit, 1);
    chk("t1_cnt", a_cnt, 2);
    chk("t1_flag", a_flag, 1);

    // Pattern 1,1 with and without overlap.
    cfg(3'd2, 16'h0003, 1'b1);
    pulse_clr();
    chk("t2_clr_cnt", a_cnt, 0);
    chk("t2_clr_flag", a_flag, 0);
    start();
    for (int i = 0; i < 4; i++) begin
      sym(4'd1);
      chk($sformatf("t2_ov1_hit%0d", i), a_hit, exp_ov1[i]);
    end
    chk("t2_ov1_cnt", a_cnt, 3);
    cfg(3'd2, 16'h0003, 1'b0);
    pulse_clr();
    start();
    for (int i = 0; i < 4; i++) begin
      sym(4'd1);
      chk($sformatf("t2_ov0_hit%0d", i), a_hit, exp_ov0[i]);
    end
    chk("t2_ov0_cnt", a_cnt, 2);

    // Rejected writes.
    cfg_wr = 1'b1; cfg_len = 3'd1; cfg_pat = 16'h0000; cfg_overlap = 1'b1;
    step();
    cfg_wr = 1'b0;
    chk("t3_err_running", a_err, 1);
    step();
    chk("t3_err_oneshot", a_err, 0);
    sym(4'd1); sym(4'd1);
    chk("t3_pat_kept", a_hit, 1);
    sym(4'd1);
    chk("t3_ovl_kept", a_hit, 0);
    cfg(3'd0, 16'h0003, 1'b0);
    chk("t3_err_len0", a_err, 1);
    start(); step();
    chk("t3_idle_len0", a_busy, 0);

    // Saturation and clear on the 2-bit counter.
    cfg(3'd1, 16'h0001, 1'b0);
    pulse_clr();
    start();
    for (int i = 0; i < 5; i++) begin
      sym(4'd1);
      chk($sformatf("t4_hit%0d", i), b_hit, 1);
      chk($sformatf("t4_cnt%0d", i), b_cnt, exp_sat[i]);
    end
    chk("t4_busy", b_busy, 1);
    pulse_clr();
    chk("t4_clr_cnt", b_cnt, 0);
    chk("t4_clr_flag", b_flag, 0);
    clr = 1'b1; in_vld = 1'b1; in_dat = 4'd1;
    step();
    clr = 1'b0; in_vld = 1'b0;
    chk("t4_clrhit_cnt", b_cnt, 1);
    chk("t4_clrhit_flag", b_flag, 1);

    // Dropping en forgets partial progress; reset mid-track clears outputs.
    cfg(3'd3, 16'h0003, 1'b0);
    pulse_clr();
    start();
    sym(4'd1); sym(4'd1);
    en = 1'b0; step();
    en = 1'b1; step();
    sym(4'd0);
    chk("t5_no_hit", a_hit, 0);
    chk("t5_busy", a_busy, 1);
    sym(4'd1); sym(4'd1); sym(4'd0);
    chk("t5_fresh_hit", a_hit, 1);
    sym(4'd1);
    rst_n = 1'b0;
    step();
    chk("t5_rst_hit", a_hit, 0); chk("t5_rst_flag", a_flag, 0); chk("t5_rst_cnt", a_cnt, 0);
    chk("t5_rst_busy", a_busy, 0); chk("t5_rst_err", a_err, 0);
    rst_n = 1'b1;

    // Invalid-symbol gaps inside a match on the 4-bit detector.
    cfg(3'd2, 16'h005A, 1'b0);
    start();
    sym(4'hA);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t6_gap%0d", i), b_hit, 0);
    end
    sym(4'h5);
    chk("t6_hit", b_hit, 1);
    chk("t6_cnt", b_cnt, 1);
    step();
    chk("t6_pulse", b_hit, 0);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
